// File: rtl/q24_8_mult_arbiter.sv
// rtl/q24_8_mult_arbiter.sv - round-robin shared signed Q24.8 multiplier with saturation
module q24_8_mult_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FRACT_BITS = 8,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*32-1:0]      req_a,
    input  logic [NUM_REQ*32-1:0]      req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       resp_valid,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [31:0]                resp_p,
    output logic                       resp_ovf,
    output logic                       resp_unf,
    input  logic                       resp_ready,
    output logic [CNT_W-1:0]           sat_count
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [31:0]       resp_p_q, resp_p_d;
    logic              resp_ovf_q, resp_ovf_d;
    logic              resp_unf_q, resp_unf_d;
    logic [CNT_W-1:0]  sat_q, sat_d;

    logic              grant_found;
    logic [ID_W-1:0]   grant_id;
    int                idx;

    logic signed [63:0] a_ext, b_ext, prod, shifted;
    logic               in_range;
    logic [31:0]        sat_p;
    logic               sat_ovf, sat_unf;

    // Round-robin search: first valid lane at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'(idx);
            end
        end
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = !rst && (state_q == IDLE) && grant_found && (grant_id == ID_W'(i));
        end
    end

    // Full-precision product, rescaled; the upper bits of the rescaled value
    // must all match the sign for the result to fit in 32 bits.
    always_comb begin
        a_ext    = {{32{a_q[31]}}, a_q};
        b_ext    = {{32{b_q[31]}}, b_q};
        prod     = a_ext * b_ext;
        shifted  = prod >>> FRACT_BITS;
        in_range = (&shifted[63:31]) | ~(|shifted[63:31]);
        sat_p    = shifted[31:0];
        sat_ovf  = 1'b0;
        sat_unf  = 1'b0;
        if (!in_range) begin
            if (!shifted[63]) begin
                sat_p   = 32'h7FFF_FFFF;
                sat_ovf = 1'b1;
            end else begin
                sat_p   = 32'h8000_0000;
                sat_unf = 1'b1;
            end
        end
    end

    // Job sequencer next-state: grant in IDLE, compute in CALC, hold until consumed.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_p_d     = resp_p_q;
        resp_ovf_d   = resp_ovf_q;
        resp_unf_d   = resp_unf_q;
        sat_d        = sat_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    a_d      = req_a[32*grant_id +: 32];
                    b_d      = req_b[32*grant_id +: 32];
                    id_d     = grant_id;
                    rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                    state_d  = CALC;
                end
            end
            CALC: begin
                resp_valid_d = 1'b1;
                resp_id_d    = id_q;
                resp_p_d     = sat_p;
                resp_ovf_d   = sat_ovf;
                resp_unf_d   = sat_unf;
                if ((sat_ovf || sat_unf) && (sat_q != {CNT_W{1'b1}})) begin
                    sat_d = sat_q + CNT_W'(1);
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers; reset discards any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_p_q     <= '0;
            resp_ovf_q   <= 1'b0;
            resp_unf_q   <= 1'b0;
            sat_q        <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_p_q     <= resp_p_d;
            resp_ovf_q   <= resp_ovf_d;
            resp_unf_q   <= resp_unf_d;
            sat_q        <= sat_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_p     = resp_p_q;
    assign resp_ovf   = resp_ovf_q;
    assign resp_unf   = resp_unf_q;
    assign sat_count  = sat_q;

endmodule

// File: tb/tb_q24_8_mult_arbiter.sv
// tb/tb_q24_8_mult_arbiter.sv - directed self-checking bench for q24_8_mult_arbiter
module tb_q24_8_mult_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_ready;
    logic         resp_valid;
    logic [1:0]   resp_id;
    logic [31:0]  resp_p;
    logic         resp_ovf;
    logic         resp_unf;
    logic         resp_ready;
    logic [15:0]  sat_count;

    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;

    q24_8_mult_arbiter #(.NUM_REQ(4), .FRACT_BITS(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_p     (resp_p),
        .resp_ovf   (resp_ovf),
        .resp_unf   (resp_unf),
        .resp_ready (resp_ready),
        .sat_count  (sat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_lanes();
        for (int i = 0; i < 4; i++) begin
            req_a[32*i +: 32] = 32'((i + 1) * 256);
            req_b[32*i +: 32] = 32'h0000_0200;
        end
    endtask

    task automatic run_job(input int lane, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ep, input logic eo, input logic eu,
                           input logic [15:0] es);
        int cycles;
        req_a[32*lane +: 32] = a;
        req_b[32*lane +: 32] = b;
        req_valid  = 4'(1 << lane);
        resp_ready = 1'b1;
        #1;
        check("job_grant", req_ready, 64'(1 << lane));
        tick();
        req_valid = 4'h0;
        cycles = 1;
        while (!resp_valid && cycles < 10) begin
            tick();
            cycles++;
        end
        check("job_latency", 64'(cycles), 64'd2);
        check("job_id", resp_id, 64'(lane));
        check("job_p", resp_p, ep);
        check("job_ovf", resp_ovf, eo);
        check("job_unf", resp_unf, eu);
        check("job_sat", sat_count, es);
        tick();
        check("job_release", resp_valid, 0);
        model_ptr = (lane + 1) % 4;
    endtask

    initial begin
        int x;
        rst        = 1'b1;
        req_valid  = 4'h0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        #3;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_p", resp_p, 0);
        check("rst_flags", {resp_ovf, resp_unf}, 0);
        check("rst_sat", sat_count, 0);
        tick();
        tick();
        rst = 1'b0;

        // All lanes valid from reset: grants 0,1,2,3,0 three cycles apart.
        load_lanes();
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int j = 0; j < 5; j++) begin
            check("rr_grant", req_ready, 64'(1 << (j % 4)));
            tick();
            check("rr_calc_ready", req_ready, 0);
            check("rr_calc_valid", resp_valid, 0);
            tick();
            check("rr_resp_valid", resp_valid, 1);
            check("rr_resp_id", resp_id, 64'(j % 4));
            check("rr_resp_p", resp_p, 64'(((j % 4) + 1) * 512));
            check("rr_hold_ready", req_ready, 0);
            tick();
        end
        req_valid = 4'h0;
        model_ptr = 1;

        run_job(2, 32'h0000_0300, 32'h0000_0200, 32'h0000_0600, 0, 0, 16'd0);
        run_job(0, 32'h7FFF_FF00, 32'h0000_0200, 32'h7FFF_FFFF, 1, 0, 16'd1);
        run_job(3, 32'h8000_0000, 32'h0000_0200, 32'h8000_0000, 0, 1, 16'd2);
        run_job(1, 32'h7FFF_FFFF, 32'h0000_0100, 32'h7FFF_FFFF, 0, 0, 16'd2);
        run_job(2, 32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 0, 0, 16'd2);
        run_job(0, 32'hFFFF_FE00, 32'h0000_0180, 32'hFFFF_FD00, 0, 0, 16'd2);
        run_job(3, 32'h0000_0180, 32'h0000_0180, 32'h0000_0240, 0, 0, 16'd2);

        // Back-pressure: hold result for 10 cycles, then next grant goes to the following lane.
        load_lanes();
        x          = model_ptr;
        req_valid  = 4'hF;
        resp_ready = 1'b0;
        #1;
        check("bp_grant", req_ready, 64'(1 << x));
        tick();
        tick();
        check("bp_valid", resp_valid, 1);
        check("bp_id", resp_id, 64'(x));
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold_valid", resp_valid, 1);
            check("bp_hold_p", resp_p, 64'((x + 1) * 512));
            check("bp_hold_id", resp_id, 64'(x));
            check("bp_hold_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        check("bp_release_valid", resp_valid, 0);
        check("bp_next_grant", req_ready, 64'(1 << ((x + 1) % 4)));

        // Reset asserted mid-job while in CALC.
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_calc_valid", resp_valid, 0);
        check("rst_calc_ready", req_ready, 0);
        check("rst_calc_p", resp_p, 0);
        check("rst_calc_sat", sat_count, 0);
        req_valid = 4'h0;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_no_resp", resp_valid, 0);
        end
        req_valid = 4'hF;
        #1;
        check("rst_rr_ptr", req_ready, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
